sqrt_step_reg: RTL and testbench

Parametrised accumulating register for the iterative square-root datapath. It holds an operand such as the running square or odd-number delta and updates it in place: load, add, add a fixed step, or saturating add. It tracks a sticky overflow flag, a one-cycle carry pulse and a saturating update counter. It generalises the fixed 17-bit square register with asymmetric reset/set presets to any width and any preset values, and adds the arithmetic modes.

---
 rtl/sqrt_step_reg.sv | 111 +++++++++++
 tb/tb_sqrt_step_reg.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sqrt_step_reg.sv
// sqrt_step_reg
//
// Accumulating operand register for the iterative square-root datapath.
// It holds a running value, such as the current square or the odd-number
// delta, and updates it in place. The update is one of: load, add, add a
// fixed step, or saturating add.
//
// The register also keeps three pieces of status:
//   - a one-cycle carry pulse,
//   - a sticky overflow flag,
//   - a saturating count of enabled updates.
//
// Every output comes straight from a flop.
//
// Ports:
//   clock      in   rising-edge clock for all state
//   reset      in   synchronous active-high; loads RESET_VALUE, clears status
//   set        in   synchronous active-high; loads SET_VALUE, clears status
//   enable     in   perform the selected mode this cycle
//   mode       in   2'b00 LOAD, 2'b01 ADD, 2'b10 STEP, 2'b11 SATADD
//   datain     in   unsigned operand for LOAD / ADD / SATADD
//   dataout    out  register contents
//   carry_out  out  high for one cycle after a carrying ADD/STEP/SATADD
//   overflow   out  sticky OR of all carries since reset/set
//   count      out  enabled updates since reset/set, saturating at all-ones

module sqrt_step_reg #(
    parameter int unsigned                WIDTH       = 17,
    parameter logic [WIDTH-1:0]           RESET_VALUE = 17'h00001,
    parameter logic [WIDTH-1:0]           SET_VALUE   = 17'h1FFFE,
    parameter int unsigned                STEP        = 2,
    parameter int unsigned                CNT_WIDTH   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 set,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     datain,
    output logic [WIDTH-1:0]     dataout,
    output logic                 carry_out,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        MODE_LOAD   = 2'b00,
        MODE_ADD    = 2'b01,
        MODE_STEP   = 2'b10,
        MODE_SATADD = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    mode_t            mode_sel;
    logic [WIDTH-1:0] operand;
    logic [WIDTH:0]   sum_ext;
    logic             sum_carry;
    logic [WIDTH-1:0] sum_val;

    // One adder is shared by ADD, STEP and SATADD. Only the operand differs.
    always_comb begin
        mode_sel  = mode_t'(mode);
        operand   = (mode_sel == MODE_STEP) ? STEP_W : datain;
        sum_ext   = {1'b0, dataout} + {1'b0, operand};
        sum_carry = sum_ext[WIDTH];
        sum_val   = sum_ext[WIDTH-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dataout   <= RESET_VALUE;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            count     <= '0;
        end else if (set) begin
            dataout   <= SET_VALUE;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            count     <= '0;
        end else if (enable) begin
            case (mode_sel)
                MODE_LOAD: begin
                    dataout   <= datain;
                    carry_out <= 1'b0;
                end
                MODE_ADD, MODE_STEP: begin
                    dataout   <= sum_val;
                    carry_out <= sum_carry;
                    overflow  <= overflow | sum_carry;
                end
                MODE_SATADD: begin
                    dataout   <= sum_carry ? '1 : sum_val;
                    carry_out <= sum_carry;
                    overflow  <= overflow | sum_carry;
                end
                default: begin
                    dataout   <= dataout;
                    carry_out <= 1'b0;
                end
            endcase
            // The counter sticks at all-ones rather than wrapping.
            if (count != '1) begin
                count <= count + CNT_WIDTH'(1);
            end
        end else begin
            carry_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sqrt_step_reg.sv
module tb_sqrt_step_reg;

    localparam int WIDTH     = 17;
    localparam int CNT_WIDTH = 2;

    localparam logic [1:0] M_LOAD = 2'b00;
    localparam logic [1:0] M_ADD  = 2'b01;
    localparam logic [1:0] M_STEP = 2'b10;
    localparam logic [1:0] M_SAT  = 2'b11;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 set = 1'b0;
    logic                 enable = 1'b0;
    logic [1:0]           mode = 2'b00;
    logic [WIDTH-1:0]     datain = '0;
    logic [WIDTH-1:0]     dataout;
    logic                 carry_out;
    logic                 overflow;
    logic [CNT_WIDTH-1:0] count;

    typedef struct {
        string                name;
        logic [WIDTH-1:0]     data;
        logic                 carry;
        logic                 ovf;
        logic [CNT_WIDTH-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pushed = 0;
    int   n_popped = 0;

    sqrt_step_reg #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(17'h00001),
        .SET_VALUE  (17'h1FFFE),
        .STEP       (2),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .set      (set),
        .enable   (enable),
        .mode     (mode),
        .datain   (datain),
        .dataout  (dataout),
        .carry_out(carry_out),
        .overflow (overflow),
        .count    (count)
    );

    always #5 clock = ~clock;

    // Drive one cycle of stimulus at the falling edge and queue its expected result.
    task automatic drive(input string nm, input logic r, input logic s, input logic en,
                         input logic [1:0] md, input logic [WIDTH-1:0] din,
                         input logic [WIDTH-1:0] e_data, input logic e_carry,
                         input logic e_ovf, input logic [CNT_WIDTH-1:0] e_cnt);
        exp_t e;
        @(negedge clock);
        reset  = r;
        set    = s;
        enable = en;
        mode   = md;
        datain = din;
        e.name  = nm;
        e.data  = e_data;
        e.carry = e_carry;
        e.ovf   = e_ovf;
        e.cnt   = e_cnt;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    // Monitor: the register presents a result every cycle; compare one queued entry per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_popped++;
                n_checks++;
                if (dataout !== e.data) begin
                    n_fail++;
                    $display("FAIL %s dataout: got %h expected %h", e.name, dataout, e.data);
                end
                n_checks++;
                if (carry_out !== e.carry) begin
                    n_fail++;
                    $display("FAIL %s carry_out: got %b expected %b", e.name, carry_out, e.carry);
                end
                n_checks++;
                if (overflow !== e.ovf) begin
                    n_fail++;
                    $display("FAIL %s overflow: got %b expected %b", e.name, overflow, e.ovf);
                end
                n_checks++;
                if (count !== e.cnt) begin
                    n_fail++;
                    $display("FAIL %s count: got %0d expected %0d", e.name, count, e.cnt);
                end
            end
        end
    end

    initial begin
        int waited;
        // presets
        drive("reset",        1, 0, 0, M_LOAD, 17'h00000, 17'h00001, 0, 0, 2'd0);
        drive("set",          0, 1, 0, M_LOAD, 17'h00000, 17'h1FFFE, 0, 0, 2'd0);
        drive("reset_and_set",1, 1, 1, M_ADD,  17'h00007, 17'h00001, 0, 0, 2'd0);
        // square / delta sequence
        drive("add3",         0, 0, 1, M_ADD,  17'h00003, 17'h00004, 0, 0, 2'd1);
        drive("add5",         0, 0, 1, M_ADD,  17'h00005, 17'h00009, 0, 0, 2'd2);
        drive("add7",         0, 0, 1, M_ADD,  17'h00007, 17'h00010, 0, 0, 2'd3);
        drive("load3",        0, 0, 1, M_LOAD, 17'h00003, 17'h00003, 0, 0, 2'd3);
        drive("step",         0, 0, 1, M_STEP, 17'h1FFFF, 17'h00005, 0, 0, 2'd3);
        // wrap and sticky overflow
        drive("reset2",       1, 0, 0, M_LOAD, 17'h00000, 17'h00001, 0, 0, 2'd0);
        drive("load_max",     0, 0, 1, M_LOAD, 17'h1FFFF, 17'h1FFFF, 0, 0, 2'd1);
        drive("add_wrap",     0, 0, 1, M_ADD,  17'h00002, 17'h00001, 1, 1, 2'd2);
        drive("load_sticky",  0, 0, 1, M_LOAD, 17'h00005, 17'h00005, 0, 1, 2'd3);
        // set with enable: enable ignored, status cleared
        drive("set_with_en",  0, 1, 1, M_ADD,  17'h00005, 17'h1FFFE, 0, 0, 2'd0);
        // saturation
        drive("load_1fff0",   0, 0, 1, M_LOAD, 17'h1FFF0, 17'h1FFF0, 0, 0, 2'd1);
        drive("satadd_20",    0, 0, 1, M_SAT,  17'h00020, 17'h1FFFF, 1, 1, 2'd2);
        drive("satadd_0",     0, 0, 1, M_SAT,  17'h00000, 17'h1FFFF, 0, 1, 2'd3);
        // consecutive carries keep carry_out high
        drive("step_wrap",    0, 0, 1, M_STEP, 17'h00000, 17'h00001, 1, 1, 2'd3);
        drive("add_wrap2",    0, 0, 1, M_ADD,  17'h1FFFF, 17'h00000, 1, 1, 2'd3);
        // hold
        drive("hold_a",       0, 0, 0, M_ADD,  17'h1ABCD, 17'h00000, 0, 1, 2'd3);
        drive("hold_b",       0, 0, 0, M_SAT,  17'h05432, 17'h00000, 0, 1, 2'd3);
        // counter saturation
        drive("reset3",       1, 0, 0, M_LOAD, 17'h00000, 17'h00001, 0, 0, 2'd0);
        drive("cnt_load1",    0, 0, 1, M_LOAD, 17'h0000A, 17'h0000A, 0, 0, 2'd1);
        drive("cnt_load2",    0, 0, 1, M_LOAD, 17'h0000B, 17'h0000B, 0, 0, 2'd2);
        drive("cnt_load3",    0, 0, 1, M_LOAD, 17'h0000C, 17'h0000C, 0, 0, 2'd3);
        drive("cnt_load4",    0, 0, 1, M_LOAD, 17'h0000D, 17'h0000D, 0, 0, 2'd3);
        drive("cnt_load5",    0, 0, 1, M_LOAD, 17'h0000E, 17'h0000E, 0, 0, 2'd3);
        drive("cnt_hold",     0, 0, 0, M_LOAD, 17'h1FFFF, 17'h0000E, 0, 0, 2'd3);
        // mid-operation reset
        drive("reset4",       1, 0, 0, M_LOAD, 17'h00000, 17'h00001, 0, 0, 2'd0);
        drive("mid_add1",     0, 0, 1, M_ADD,  17'h00003, 17'h00004, 0, 0, 2'd1);
        drive("mid_add2",     0, 0, 1, M_ADD,  17'h00003, 17'h00007, 0, 0, 2'd2);
        drive("mid_reset",    1, 0, 1, M_ADD,  17'h00003, 17'h00001, 0, 0, 2'd0);
        drive("post_add",     0, 0, 1, M_ADD,  17'h00003, 17'h00004, 0, 0, 2'd1);
        drive("satadd_nocar", 0, 0, 1, M_SAT,  17'h00005, 17'h00009, 0, 0, 2'd2);

        @(negedge clock);
        enable = 1'b0;
        reset  = 1'b0;
        set    = 1'b0;

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        n_checks++;
        if (exp_q.size() != 0 || n_popped != n_pushed) begin
            n_fail++;
            $display("FAIL drain: popped %0d expected %0d", n_popped, n_pushed);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
